// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared types, field limits and helper functions for the timekeeper.
package timekeeper_pkg;

   typedef enum logic [1:0] {
      FIELD_H = 2'd0,
      FIELD_M = 2'd1,
      FIELD_S = 2'd2
   } field_t;

   localparam logic [5:0] SEC_MAX = 6'd59;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [4:0] HR_MAX  = 5'd23;

   typedef struct packed {
      logic [4:0] hr;
      logic       pm;
   } hr12_t;

   // 24 h -> 12 h presentation: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM
   function automatic hr12_t to_12h(input logic [4:0] hr24);
      hr12_t r;
      r.pm = (hr24 >= 5'd12);
      if (hr24 == 5'd0)       r.hr = 5'd12;
      else if (hr24 > 5'd12)  r.hr = hr24 - 5'd12;
      else                    r.hr = hr24;
      return r;
   endfunction

   // +/-1 with wrap inside [0, max]; never carries into a neighbouring field
   function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max,
                                            input logic up);
      logic [5:0] r;
      if (up) r = (v == max)  ? 6'd0 : v + 6'd1;
      else    r = (v == 6'd0) ? max  : v - 6'd1;
      return r;
   endfunction

   function automatic field_t next_field(input field_t f);
      field_t r;
      case (f)
         FIELD_H: r = FIELD_M;
         FIELD_M: r = FIELD_S;
         default: r = FIELD_H;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/button_qualifier.sv
// button_qualifier: hold-qualified push button with optional auto-repeat.
// First action fires in the cycle the hold count reaches HOLD_CYCLES; with
// repeat enabled it fires again every REPEAT_CYCLES cycles while held.
module button_qualifier #(
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 12_500_000,
   parameter bit REPEAT_ON     = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic btn,
   output logic action
);

   localparam bit RPT_EN = REPEAT_ON && (REPEAT_CYCLES > 0);
   // Without repeat the counter parks one past HOLD so the action fires only once.
   localparam int SAT    = RPT_EN ? HOLD_CYCLES : HOLD_CYCLES + 1;
   localparam int CW     = $clog2(HOLD_CYCLES + 2);
   localparam int RPT    = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1;
   localparam int RW     = (RPT > 1) ? $clog2(RPT) : 1;

   localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] CNT_SAT  = CW'(SAT);
   localparam logic [RW-1:0] REP_LAST = RW'(RPT - 1);

   logic [CW-1:0] cnt;
   logic [RW-1:0] rep;

   // Hold counter saturates; repeat phase counter runs once the hold is qualified.
   always_ff @(posedge clk) begin
      if (reset || !en || !btn) begin
         cnt <= '0;
         rep <= '0;
      end else begin
         if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
         if (RPT_EN && cnt == CNT_HOLD) rep <= (rep == REP_LAST) ? '0 : rep + 1'b1;
      end
   end

   assign action = en && (cnt == CNT_HOLD) && (!RPT_EN || rep == '0);

endmodule

// File: rtl/configurable_timekeeper.sv
// configurable_timekeeper: 24 h H:M:S counter with in-place editing and 12 h output.
// Optional alarm comparator compiled in with `define ALARM_EN.
module configurable_timekeeper
   import timekeeper_pkg::*;
#(
   parameter int CLK_HZ        = 100_000_000,
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int REPEAT_CYCLES = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       edit,
   input  logic       field_next,
   input  logic       inc,
   input  logic       dec,
   input  logic       mode_12h,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       pm,
   output logic [1:0] field_sel,
`ifdef ALARM_EN
   input  logic [4:0] alarm_hours,
   input  logic [5:0] alarm_minutes,
   input  logic       alarm_arm,
   input  logic       alarm_ack,
   output logic       alarm,
`endif
   output logic       tick
);

   localparam int            PW      = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   logic [PW-1:0] presc, presc_n;
   logic [4:0]    hr, hr_n;
   logic [5:0]    min, min_n, sec, sec_n;
   field_t        fsel, fsel_n;
   logic          edit_q, tick_n;
   logic [2:0]    btn, act;
   hr12_t         h12;

   // Bit order sets index 0 as field_next, the only button that never repeats.
   assign btn = {dec, inc, field_next};

   for (genvar i = 0; i < 3; i++) begin : g_q
      button_qualifier #(
         .HOLD_CYCLES  (HOLD_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .REPEAT_ON    (i != 0)
      ) u_q (
         .clk   (clk),
         .reset (reset),
         .en    (edit),
         .btn   (btn[i]),
         .action(act[i])
      );
   end

   // Next state: edit freezes time and applies one button action; run advances the prescaler.
   always_comb begin
      presc_n = presc;
      hr_n    = hr;
      min_n   = min;
      sec_n   = sec;
      fsel_n  = fsel;
      tick_n  = 1'b0;
      if (edit) begin
         presc_n = '0;
         if (!edit_q)
            fsel_n = FIELD_H;
         else if (act[0])
            fsel_n = next_field(fsel);
         else if (act[1] || act[2]) begin
            case (fsel)
               FIELD_H: hr_n  = 5'(step_wrap({1'b0, hr}, {1'b0, HR_MAX}, act[1]));
               FIELD_M: min_n = step_wrap(min, MIN_MAX, act[1]);
               default: sec_n = step_wrap(sec, SEC_MAX, act[1]);
            endcase
         end
      end else if (presc == PRE_MAX) begin
         presc_n = '0;
         tick_n  = 1'b1;
         if (sec == SEC_MAX) begin
            sec_n = '0;
            if (min == MIN_MAX) begin
               min_n = '0;
               hr_n  = (hr == HR_MAX) ? 5'd0 : hr + 5'd1;
            end else
               min_n = min + 6'd1;
         end else
            sec_n = sec + 6'd1;
      end else
         presc_n = presc + 1'b1;
   end

   // State register; tick is registered so it lines up with the new seconds value.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc  <= '0;
         hr     <= '0;
         min    <= '0;
         sec    <= '0;
         fsel   <= FIELD_H;
         edit_q <= 1'b0;
         tick   <= 1'b0;
      end else begin
         presc  <= presc_n;
         hr     <= hr_n;
         min    <= min_n;
         sec    <= sec_n;
         fsel   <= fsel_n;
         edit_q <= edit;
         tick   <= tick_n;
      end
   end

`ifdef ALARM_EN
   // Latch on the tick that lands on alarm_hours:alarm_minutes:00; ack beats set.
   always_ff @(posedge clk) begin
      if (reset || alarm_ack || !alarm_arm)
         alarm <= 1'b0;
      else if (tick_n && hr_n == alarm_hours && min_n == alarm_minutes && sec_n == 6'd0)
         alarm <= 1'b1;
   end
`endif

   assign h12       = to_12h(hr);
   assign hours     = mode_12h ? h12.hr : hr;
   assign pm        = mode_12h & h12.pm;
   assign minutes   = min;
   assign seconds   = sec;
   assign field_sel = fsel;

endmodule

// File: tb/tb_configurable_timekeeper.sv
// tb_configurable_timekeeper: directed scoreboard bench (CLK_HZ=10, HOLD=3, REPEAT=4).
module tb_configurable_timekeeper;

   logic       clk = 1'b0;
   logic       reset, edit, field_next, inc, dec, mode_12h;
   logic [4:0] hours;
   logic [5:0] minutes, seconds;
   logic       pm, tick;
   logic [1:0] field_sel;
`ifdef ALARM_EN
   logic [4:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       alarm_arm, alarm_ack, alarm;
`endif

   configurable_timekeeper #(.CLK_HZ(10), .HOLD_CYCLES(3), .REPEAT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .edit(edit), .field_next(field_next), .inc(inc), .dec(dec),
      .mode_12h(mode_12h), .hours(hours), .minutes(minutes), .seconds(seconds), .pm(pm),
      .field_sel(field_sel),
`ifdef ALARM_EN
      .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_arm(alarm_arm),
      .alarm_ack(alarm_ack), .alarm(alarm),
`endif
      .tick(tick));

   always #5 clk = ~clk;

   typedef struct {
      string nm;
      int    h, m, s, p, fs, al;
   } snap_t;

   snap_t exp_q[$];
   int    tick_q[$];
   int    cyc = 0;
   int    checks = 0, errors = 0;
   logic  sample_req = 1'b0;
   logic  tick_chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: state snapshots on request, tick pulses against expected cycle numbers.
   always @(negedge clk) begin
      snap_t e;
      int    t;
      bit    bad;
      if (sample_req) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got a sample request, required an expected entry");
         end else begin
            e = exp_q.pop_front();
            bad = (hours != e.h) || (minutes != e.m) || (seconds != e.s) || (pm != e.p) ||
                  (field_sel != e.fs);
`ifdef ALARM_EN
            bad = bad || (alarm != e.al);
`endif
            if (bad) begin
               errors++;
               $display("FAIL %s: got %0d:%0d:%0d pm=%0d fs=%0d, required %0d:%0d:%0d pm=%0d fs=%0d al=%0d",
                        e.nm, hours, minutes, seconds, pm, field_sel,
                        e.h, e.m, e.s, e.p, e.fs, e.al);
            end
         end
      end
      if (tick_chk_en && tick) begin
         checks++;
         if (tick_q.size() == 0) begin
            errors++;
            $display("FAIL tick_extra: got tick at cycle %0d, required none", cyc);
         end else begin
            t = tick_q.pop_front();
            if (t != cyc) begin
               errors++;
               $display("FAIL tick_time: got tick at cycle %0d, required cycle %0d", cyc, t);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int h, m, s, p, fs, al);
      snap_t e;
      e.nm = nm; e.h = h; e.m = m; e.s = s; e.p = p; e.fs = fs; e.al = al;
      exp_q.push_back(e);
      sample_req = 1'b1;
      @(negedge clk);
      #1 sample_req = 1'b0;
   endtask

   task automatic chk_ticks_done(input string nm);
      checks++;
      if (tick_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d ticks still outstanding, required 0", nm, tick_q.size());
      end
   endtask

   // mask = {dec, inc, field_next}; held for n cycles then released with settle time
   task automatic press(input logic [2:0] mask, input int n);
      {dec, inc, field_next} = mask;
      step(n);
      {dec, inc, field_next} = 3'b000;
      step(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, required finish within time limit");
      $fatal(1);
   end

   initial begin
      int r;
      reset = 1'b1; edit = 1'b0; field_next = 1'b0; inc = 1'b0; dec = 1'b0; mode_12h = 1'b0;
`ifdef ALARM_EN
      alarm_hours = 5'd0; alarm_minutes = 6'd0; alarm_arm = 1'b0; alarm_ack = 1'b0;
`endif
      step(2);
      reset = 1'b0;
      r = cyc;
      chk("reset_state", 0, 0, 0, 0, 0, 0);

      // 600 run cycles: 60 ticks every 10 cycles
      for (int i = 1; i <= 60; i++) tick_q.push_back(r + 10 * i);
      tick_chk_en = 1'b1;
      step(600);
      chk("run_600", 0, 1, 0, 0, 0, 0);
      chk_ticks_done("tick_count_600");
      tick_chk_en = 1'b0;

      // preload 23:59:59 through edit, then release for the midnight rollover
      edit = 1'b1;
      step(1);
      press(3'b100, 3);
      chk("edit_dec_hr_wrap", 23, 1, 0, 0, 0, 0);
      press(3'b001, 3);
      press(3'b100, 3);
      press(3'b100, 3);
      chk("edit_dec_min_wrap", 23, 59, 0, 0, 1, 0);
      press(3'b001, 3);
      press(3'b100, 3);
      chk("preload_235959", 23, 59, 59, 0, 2, 0);
      edit = 1'b0;
      tick_q.push_back(cyc + 10);
      tick_chk_en = 1'b1;
      step(10);
      chk("midnight_rollover", 0, 0, 0, 0, 2, 0);
      chk_ticks_done("tick_rollover");
      tick_chk_en = 1'b0;

      // minutes field: inc wraps 59->0 without touching hours, then auto-repeat
      edit = 1'b1;
      step(1);
      chk("field_reset_on_edit", 0, 0, 0, 0, 0, 0);
      press(3'b001, 3);
      press(3'b100, 3);
      chk("min_at_59", 0, 59, 0, 0, 1, 0);
      press(3'b010, 3);
      chk("inc_min_wrap_no_carry", 0, 0, 0, 0, 1, 0);
      press(3'b100, 3);
      press(3'b010, 11);
      chk("inc_repeat_3_actions", 0, 2, 0, 0, 1, 0);

      // field_next priority and non-repeat
      press(3'b001, 3);
      press(3'b001, 3);
      chk("field_wrap_s_to_h", 0, 2, 0, 0, 0, 0);
      press(3'b011, 3);
      chk("field_next_beats_inc", 0, 2, 0, 0, 1, 0);
      press(3'b001, 20);
      chk("field_next_no_repeat", 0, 2, 0, 0, 2, 0);

      // 12 h presentation
      mode_12h = 1'b1;
      chk("12h_midnight", 12, 2, 0, 0, 2, 0);
      press(3'b001, 3);
      press(3'b010, 51);
      chk("12h_13h", 1, 2, 0, 1, 0, 0);
      mode_12h = 1'b0;
      chk("24h_13h", 13, 2, 0, 0, 0, 0);

      // reset in the middle of an inc hold: no action survives
      inc = 1'b1;
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      inc = 1'b0;
      step(3);
      chk("reset_mid_hold", 0, 0, 0, 0, 0, 0);
      mode_12h = 1'b1;
      chk("reset_12h", 12, 0, 0, 0, 0, 0);
      mode_12h = 1'b0;

`ifdef ALARM_EN
      press(3'b001, 3);
      press(3'b001, 3);
      press(3'b100, 19);
      alarm_hours = 5'd0; alarm_minutes = 6'd1; alarm_arm = 1'b1;
      chk("alarm_preload", 0, 0, 55, 0, 2, 0);
      edit = 1'b0;
      step(40);
      chk("alarm_not_yet", 0, 0, 59, 0, 2, 0);
      step(10);
      chk("alarm_set", 0, 1, 0, 0, 2, 1);
      alarm_ack = 1'b1;
      step(1);
      alarm_ack = 1'b0;
      chk("alarm_ack", 0, 1, 0, 0, 2, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/configurable_timekeeper.md
# configurable_timekeeper

Parametrised hours/minutes/seconds timekeeper with in-place editing, for board designs that drive a seven-segment or other time display. Counts real time from a free-running clock of configurable frequency and freezes while editing. In edit mode, the selected field (H, M or S) is adjusted with qualified, auto-repeating push-button inputs. Presents binary time in 24 h or 12 h form to a downstream digit splitter; an optional alarm comparator can be compiled in.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; one second = CLK_HZ cycles (≥2)
- HOLD_CYCLES, 25_000_000, consecutive cycles a button must be held before its first action (≥1)
- REPEAT_CYCLES, 12_500_000, auto-repeat period for inc/dec while held; 0 disables repeat
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- edit  in  1  level; 1 = edit mode (time frozen), 0 = run
- field_next  in  1  raw button; advance edit field H→M→S→H
- inc  in  1  raw button; increment selected field
- dec  in  1  raw button; decrement selected field
- mode_12h  in  1  level; 1 = 12 h presentation
- hours  out  5  0–23 (24 h) or 1–12 (12 h)
- minutes  out  6  0–59
- seconds  out  6  0–59
- pm  out  1  12 h mode: 1 when internal hour ≥12; 24 h mode: 0
- field_sel  out  2  0 = H, 1 = M, 2 = S; 3 never produced
- tick  out  1  one-cycle pulse per elapsed second in run mode
- alarm_hours, alarm_minutes  in  5/6  alarm time, 24 h (ALARM_EN only)
- alarm_arm, alarm_ack  in  1  arm level / clear pulse (ALARM_EN only)
- alarm  out  1  alarm indicator (ALARM_EN only)

## Operation
- Internal time is always 24 h (hr 0–23, min 0–59, sec 0–59). The 12 h mapping is combinational on output: hr 0→12 pm=0; 1–11→same pm=0; 12→12 pm=1; 13–23→hr−12 pm=1.
- Run (edit=0): prescaler counts 0..CLK_HZ−1. At CLK_HZ−1 the prescaler returns to 0, sec increments, tick=1.
  - Carries: 59→0 into min; 59→0 into hr; 23:59:59→00:00:00.
- Edit (edit=1): prescaler held at 0, tick=0, time holds except for button actions. On leaving edit, the next tick comes a full CLK_HZ cycles later.
- Button qualifier, per button: a hold counter counts consecutive high cycles and clears on any low cycle.
  - First action fires in the cycle the count reaches HOLD_CYCLES.
  - inc/dec then fire again every REPEAT_CYCLES cycles while held (if non-zero).
  - field_next never repeats.
  - Qualifiers run only while edit=1 and are cleared while edit=0.
- Action priority within a cycle: field_next > inc > dec. Lower-priority actions in that cycle are discarded.
- inc/dec wrap inside the field: hr 23↔0, min/sec 59↔0. No carry into other fields.
- field_sel resets to H when edit goes 0→1.

## Timing
- Reset values: hours=0 (12 in 12 h mode), minutes=0, seconds=0, pm=0, field_sel=0, tick=0, alarm=0. Prescaler and hold counters are 0.
- tick is registered and asserts in the same cycle the new seconds value is visible.
- Button action latency: the field value changes at the clock edge after the cycle in which the hold count reaches HOLD_CYCLES. With stimulus asserted before edge 1, the new value is visible after edge HOLD_CYCLES+1.
- edit toggled in the same cycle as a prescaler wrap: edit wins; no tick, no increment.
- mode_12h change takes effect immediately on outputs; no state change.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of edit or buttons.

## Configuration
- ALARM_EN defined: an alarm latch sets when alarm_arm=1, run mode, and the internal hr:min equals alarm_hours:alarm_minutes while sec=0 on a tick.
  - Cleared by alarm_ack (priority over set) or by alarm_arm=0.
  - Alarm ports exist.
- ALARM_EN undefined: alarm logic and all alarm ports are absent.

## Structure
- Package timekeeper_pkg: field enum (FIELD_H, FIELD_M, FIELD_S), constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, 12 h mapping function.
- Sub-module button_qualifier (params HOLD_CYCLES, REPEAT_CYCLES, REPEAT_ON): three instances, outputs a one-cycle action pulse.

## Test plan
Bench params: CLK_HZ=10, HOLD_CYCLES=3, REPEAT_CYCLES=4.
- Reset, run 600 cycles → 00:01:00, exactly 60 tick pulses spaced 10 cycles.
- Preload 23:59:59 via edit, release, wait 10 cycles → 00:00:00 with one tick.
- Edit, field M at 59, inc held 3 cycles → minutes=0, hours unchanged. Held 11 cycles total → 3 actions (min=2).
- Edit, field_next and inc held together 3 cycles → field_sel=1, no value change. field_next held 20 cycles → exactly one advance.
- mode_12h=1 at internal 00:xx and 13:xx → hours=12 pm=0, hours=1 pm=1. Reset asserted during an inc hold → all zero, no action.
- ALARM_EN: alarm 00:01 armed, run from 00:00:55 → alarm=1 at the 00:01:00 tick. alarm_ack → 0.
